// File: rtl/run_pkg.sv
// Shared types and defaults for the run controller slice.
package run_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_t;

    localparam int HALT_PC_DEF = 128;
    localparam int TIMEOUT_DEF = 65535;

endpackage

// File: rtl/run_ctrl_if.sv
// Host <-> run controller handshake plus the core-facing control/status.
interface run_ctrl_if #(
    parameter int D  = 12,
    parameter int CW = 16
);
    logic          req;
    logic [D-1:0]  prog_ctr;
    logic          core_rst;
    logic          core_en;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycles;

    modport master (
        output req, prog_ctr,
        input  core_rst, core_en, busy, done, timeout, cycles
    );

    modport slave (
        input  req, prog_ctr,
        output core_rst, core_en, busy, done, timeout, cycles
    );
endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones.
module sat_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: holds the core in reset while idle, runs it until halt PC
// or timeout, then freezes it and raises a registered done until req drops.
module run_ctrl
    import run_pkg::*;
#(
    parameter int D           = 12,
    parameter int HALT_PC     = HALT_PC_DEF,
    parameter int RST_CYC     = 2,
    parameter int CW          = 16,
    parameter int TIMEOUT_CYC = TIMEOUT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    run_ctrl_if.slave  bus
);

    localparam int IW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

    run_state_t    state, state_nxt;
    logic [IW-1:0] init_cnt;
    logic          timeout_q;
    logic [CW-1:0] cycles;
    logic          halt, tmo, start;

    assign halt  = (bus.prog_ctr == D'(HALT_PC));
    assign tmo   = (cycles == CW'(TIMEOUT_CYC - 1));
    assign start = (state == IDLE) && bus.req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.req)                         state_nxt = INIT;
            INIT:    if (init_cnt == IW'(RST_CYC - 1))    state_nxt = RUN;
            RUN:     if (halt || tmo)                     state_nxt = DONE;
            DONE:    if (!bus.req)                        state_nxt = IDLE;
            default:                                      state_nxt = IDLE;
        endcase
    end

    // Halt has priority over a coincident timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (start) begin
                init_cnt  <= '0;
                timeout_q <= 1'b0;
            end
            if (state == INIT)
                init_cnt <= init_cnt + 1'b1;
            if (state == RUN) begin
                if (halt)     timeout_q <= 1'b0;
                else if (tmo) timeout_q <= 1'b1;
            end
        end
    end

    sat_counter #(.CW(CW)) u_cycles (
        .clk   (clk),
        .reset (reset),
        .clr   (start),
        .en    (state == RUN),
        .q     (cycles)
    );

    // Everything below decodes registered state only.
    assign bus.core_rst = (state == IDLE) || (state == INIT);
    assign bus.core_en  = (state == RUN);
    assign bus.busy     = (state == INIT) || (state == RUN);
    assign bus.done     = (state == DONE);
    assign bus.timeout  = timeout_q;
    assign bus.cycles   = cycles;

endmodule

// File: tb/tb_run_ctrl.sv
// Four run_ctrl instances with different timeouts driven by one req; a simple
// core PC model per instance and a min(halt, timeout) outcome model.
module tb_run_ctrl;
    import run_pkg::*;

    localparam int NI = 4;
    localparam int TO[NI] = '{300, 20, 129, 255};

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        stuck;
    logic [11:0] start_pc;
    int          run_id = 0;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    run_ctrl_if #(.D(12), .CW(16)) b0 ();
    run_ctrl_if #(.D(12), .CW(16)) b1 ();
    run_ctrl_if #(.D(12), .CW(16)) b2 ();
    run_ctrl_if #(.D(12), .CW(8))  b3 ();

    run_ctrl #(.TIMEOUT_CYC(300))        d0 (.clk(clk), .reset(reset), .bus(b0));
    run_ctrl #(.TIMEOUT_CYC(20))         d1 (.clk(clk), .reset(reset), .bus(b1));
    run_ctrl #(.TIMEOUT_CYC(129))        d2 (.clk(clk), .reset(reset), .bus(b2));
    run_ctrl #(.CW(8), .TIMEOUT_CYC(255)) d3 (.clk(clk), .reset(reset), .bus(b3));

    logic [11:0] pc [NI];
    logic        rst_a [NI], en_a [NI], busy_a [NI], done_a [NI], to_a [NI];
    logic [15:0] cyc_a [NI];

    assign b0.req = req; assign b0.prog_ctr = stuck ? 12'd5 : pc[0];
    assign b1.req = req; assign b1.prog_ctr = stuck ? 12'd5 : pc[1];
    assign b2.req = req; assign b2.prog_ctr = stuck ? 12'd5 : pc[2];
    assign b3.req = req; assign b3.prog_ctr = stuck ? 12'd5 : pc[3];

    assign rst_a[0] = b0.core_rst; assign en_a[0] = b0.core_en; assign busy_a[0] = b0.busy;
    assign rst_a[1] = b1.core_rst; assign en_a[1] = b1.core_en; assign busy_a[1] = b1.busy;
    assign rst_a[2] = b2.core_rst; assign en_a[2] = b2.core_en; assign busy_a[2] = b2.busy;
    assign rst_a[3] = b3.core_rst; assign en_a[3] = b3.core_en; assign busy_a[3] = b3.busy;
    assign done_a[0] = b0.done; assign to_a[0] = b0.timeout; assign cyc_a[0] = b0.cycles;
    assign done_a[1] = b1.done; assign to_a[1] = b1.timeout; assign cyc_a[1] = b1.cycles;
    assign done_a[2] = b2.done; assign to_a[2] = b2.timeout; assign cyc_a[2] = b2.cycles;
    assign done_a[3] = b3.done; assign to_a[3] = b3.timeout; assign cyc_a[3] = {8'd0, b3.cycles};

    // Core model: PC loads start_pc while held in reset, advances while enabled.
    always @(posedge clk)
        for (int i = 0; i < NI; i++)
            if (rst_a[i])     pc[i] <= start_pc;
            else if (en_a[i]) pc[i] <= pc[i] + 12'd1;

    // Latch the outcome on the first cycle done is seen for each instance.
    logic done_d [NI] = '{default: 1'b0};
    int   cap_id [NI] = '{default: 0};
    int   cap_cyc[NI];
    logic cap_to [NI];
    always @(negedge clk)
        for (int i = 0; i < NI; i++) begin
            done_d[i] <= done_a[i];
            if (done_a[i] && !done_d[i]) begin
                cap_id[i]  <= run_id;
                cap_cyc[i] <= int'(cyc_a[i]);
                cap_to[i]  <= to_a[i];
            end
        end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Halt at PC 128 happens on RUN edge 129-start; halt wins a tie with timeout.
    function automatic void predict(input int to, input bit stk, input int s,
                                    output int cyc, output bit tmo);
        int h;
        h = stk ? 32'h4000_0000 : (129 - s);
        if (h <= to) begin cyc = h;  tmo = 1'b0; end
        else         begin cyc = to; tmo = 1'b1; end
    endfunction

    task automatic check_idle(input string tag);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("%s.core_rst[%0d]", tag, i), rst_a[i], 1);
            chk($sformatf("%s.core_en[%0d]", tag, i), en_a[i], 0);
            chk($sformatf("%s.busy[%0d]", tag, i), busy_a[i], 0);
            chk($sformatf("%s.done[%0d]", tag, i), done_a[i], 0);
        end
    endtask

    task automatic do_run(input bit stk, input int s, input int drop_at);
        int  k;
        bit  all;
        int  ecyc;
        bit  eto;
        @(negedge clk);
        stuck = stk; start_pc = 12'(s);
        @(negedge clk);
        run_id++;
        req = 1'b1;
        all = 1'b0;
        k = 0;
        while (!all && k < 2000) begin
            @(negedge clk);
            k++;
            for (int i = 0; i < NI; i++) begin
                if (k <= 2) begin
                    chk($sformatf("init%0d.core_rst[%0d]", k, i), rst_a[i], 1);
                    chk($sformatf("init%0d.busy[%0d]", k, i), busy_a[i], 1);
                    chk($sformatf("init%0d.cycles[%0d]", k, i), cyc_a[i], 0);
                end else if (k == 3) begin
                    chk($sformatf("run.core_en[%0d]", i), en_a[i], 1);
                    chk($sformatf("run.core_rst[%0d]", i), rst_a[i], 0);
                end
            end
            if (k == drop_at) req = 1'b0;
            all = 1'b1;
            for (int i = 0; i < NI; i++) if (cap_id[i] != run_id) all = 1'b0;
        end
        chk("run_completes", all, 1);
        for (int i = 0; i < NI; i++) begin
            predict(TO[i], stk, s, ecyc, eto);
            chk($sformatf("cycles[%0d]", i), cap_cyc[i], ecyc);
            chk($sformatf("timeout[%0d]", i), cap_to[i], eto);
        end
        if (req) begin
            repeat (10) begin
                @(negedge clk);
                for (int i = 0; i < NI; i++) begin
                    chk($sformatf("hold.done[%0d]", i), done_a[i], 1);
                    chk($sformatf("hold.core_en[%0d]", i), en_a[i], 0);
                    chk($sformatf("hold.core_rst[%0d]", i), rst_a[i], 0);
                    chk($sformatf("hold.cycles[%0d]", i), cyc_a[i], cap_cyc[i]);
                end
            end
            req = 1'b0;
        end
        @(negedge clk);
        check_idle("after_done");
    endtask

    initial begin
        int s, drop;
        bit stk;
        reset = 1'b1; req = 1'b0; stuck = 1'b0; start_pc = '0;
        repeat (2) @(negedge clk);
        check_idle("reset");
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset.cycles[%0d]", i), cyc_a[i], 0);
            chk($sformatf("reset.timeout[%0d]", i), to_a[i], 0);
        end
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_reset");

        do_run(1'b0, 0, -1);     // normal program, coincident tie on d2
        do_run(1'b1, 0, -1);     // stuck PC: every instance times out
        do_run(1'b0, 0, 1);      // req dropped during INIT
        do_run(1'b0, 0, 50);     // req dropped during RUN
        do_run(1'b0, 128, -1);   // halt on the very first RUN edge

        // Async reset between edges, mid-run.
        @(negedge clk);
        stuck = 1'b0; start_pc = '0;
        req = 1'b1;
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_idle("async_reset");
        for (int i = 0; i < NI; i++)
            chk($sformatf("async_reset.cycles[%0d]", i), cyc_a[i], 0);
        req = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("after_async");

        for (int n = 0; n < 12; n++) begin
            stk  = ($urandom % 6) == 0;
            s    = int'($urandom_range(0, 128));
            drop = (($urandom % 3) == 0) ? int'($urandom_range(1, 140)) : -1;
            do_run(stk, s, drop);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
